// File: rtl/nb_neg_arbiter.sv
// Round-robin arbiter in front of a single two's-complement negation unit with a
// one-entry valid/ready result slot. Optional build macro: NEG_SAT_EN (saturate -MIN).
module nb_neg_arbiter #(
    parameter  int n    = 16,
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*n-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [n-1:0]      out_data,
    output logic [IDW-1:0]    out_id,
    output logic              out_ovf,
    output logic              dbg_state_o
);

    // Handshake: a result moves to the consumer on any edge where out_valid && out_ready;
    // an operand moves in on any edge where ack[i] is high (ack implies the slot can take it).
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e        state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [n-1:0]       data_q, data_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               ovf_q, ovf_d;

    logic               found;
    logic [IDW-1:0]     win;
    logic               accept;
    logic [n-1:0]       op;
    logic [n-1:0]       neg;
    logic               op_is_min;
    logic [n-1:0]       result;

    function automatic logic [IDW-1:0] wrap_idx(input int base, input int k);
        int s;
        s = base + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Rotating priority search starting at the pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[wrap_idx(int'(ptr_q), k)]) begin
                found = 1'b1;
                win   = wrap_idx(int'(ptr_q), k);
            end
        end
    end

    assign accept    = found && ((state_q == EMPTY) || out_ready);
    assign op        = req_data[int'(win)*n +: n];
    assign neg       = ~op + 1'b1;
    assign op_is_min = (op == {1'b1, {(n-1){1'b0}}});

`ifdef NEG_SAT_EN
    assign result = op_is_min ? {1'b0, {(n-1){1'b1}}} : neg;
`else
    assign result = neg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        ovf_d   = ovf_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            data_d = result;
            id_d   = win;
            ovf_d  = op_is_min;
            ptr_d  = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
        end
    end

    // ack is forced low while reset is held so no requester retires an operand that is discarded.
    always_comb begin
        ack         = '0;
        if (accept && rst_n) ack = {{(NREQ-1){1'b0}}, 1'b1} << win;
        out_valid   = (state_q == FULL);
        out_data    = data_q;
        out_id      = id_q;
        out_ovf     = ovf_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_nb_neg_arbiter.sv
// Bench for nb_neg_arbiter: directed scenarios plus randomized traffic checked by a
// cycle-level scoreboard model of the arbiter and result slot.
module tb_nb_neg_arbiter;

    localparam int N    = 16;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = N + IDW + 1;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_data;
    logic [IDW-1:0]    out_id;
    logic              out_ovf;
    logic              dbg_state;

    int checks = 0;
    int fails  = 0;

    nb_neg_arbiter #(.n(N), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_id      (out_id),
        .out_ovf     (out_ovf),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, fails=%0d", fails);
        $fatal(1, "watchdog");
    end

    // ---------------- reference arithmetic ----------------
    function automatic logic [N-1:0] ref_neg(input logic [N-1:0] op);
        longint m;
        m = longint'(1) << N;
`ifdef NEG_SAT_EN
        if (op == 16'h8000) return 16'h7FFF;
`endif
        return N'((m - longint'(op)) % m);
    endfunction

    function automatic logic ref_ovf(input logic [N-1:0] op);
        return longint'(op) == (longint'(1) << (N-1));
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           ptr_m = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ack;
        logic [N-1:0]    op;
        logic            full, acc;
        int              w;
        if (!rst_n) begin
            checks++;
            if (ack !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_id !== '0 || out_ovf !== 1'b0) begin
                fails++;
                $display("FAIL sb_reset t=%0t: ack=%b valid=%b data=%h id=%0d ovf=%b, required all zero",
                         $time, ack, out_valid, out_data, out_id, out_ovf);
            end
            ptr_m = 0;
            exp_q.delete();
        end else begin
            full    = (exp_q.size() != 0);
            acc     = (req != '0) && (!full || out_ready);
            exp_ack = '0;
            w       = -1;
            if (acc) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && req[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
                end
                exp_ack[w] = 1'b1;
            end
            checks++;
            if (ack !== exp_ack) begin
                fails++;
                $display("FAIL sb_ack t=%0t: ack=%b required %b", $time, ack, exp_ack);
            end
            checks++;
            if (out_valid !== full) begin
                fails++;
                $display("FAIL sb_valid t=%0t: out_valid=%b required %b", $time, out_valid, full);
            end
            if (full) begin
                checks++;
                if ({out_id, out_ovf, out_data} !== exp_q[0]) begin
                    fails++;
                    $display("FAIL sb_result t=%0t: id=%0d ovf=%b data=%h required id=%0d ovf=%b data=%h",
                             $time, out_id, out_ovf, out_data,
                             exp_q[0][W-1 -: IDW], exp_q[0][N], exp_q[0][N-1:0]);
                end
            end
            if (full && out_ready) void'(exp_q.pop_front());
            if (acc) begin
                op = req_data[w*N +: N];
                exp_q.push_back({IDW'(w), ref_ovf(op), ref_neg(op)});
                ptr_m = (w + 1) % NREQ;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(output logic [NREQ-1:0] a);
        @(negedge clk);
        a = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic [NREQ-1:0] a;
        req       = '0;
        out_ready = 1'b1;
        repeat (3) tick(a);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        req       = '0;
        req_data  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_id !== '0 || out_ovf !== 1'b0 || ack !== '0) begin
            fails++;
            $display("FAIL reset_state: valid=%b data=%h id=%0d ovf=%b ack=%b, required zeros",
                     out_valid, out_data, out_id, out_ovf, ack);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== '0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: ack=%b valid=%b, required 0 0", ack, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_a;
        logic [N-1:0]    exp_d;
        for (int i = 0; i < NREQ; i++) req_data[i*N +: N] = N'(i + 1);
        req       = '1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_a = NREQ'(1) << (k % NREQ);
            checks++;
            if (ack !== exp_a) begin
                fails++;
                $display("FAIL rr_ack k=%0d: ack=%b required %b", k, ack, exp_a);
            end
            if (k > 0) begin
                exp_d = N'(17'h10000 - ((k - 1) % NREQ + 1));
                checks++;
                if (out_valid !== 1'b1 || out_id !== IDW'((k - 1) % NREQ) || out_data !== exp_d) begin
                    fails++;
                    $display("FAIL rr_out k=%0d: valid=%b id=%0d data=%h required 1 %0d %h",
                             k, out_valid, out_id, out_data, (k - 1) % NREQ, exp_d);
                end
            end
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic test_single();
        logic [NREQ-1:0] a;
        req_data[0 +: N] = 16'h0005;
        req       = 4'b0001;
        out_ready = 1'b1;
        tick(a);
        checks++;
        if (a !== 4'b0001) begin
            fails++;
            $display("FAIL single_ack: ack=%b required 0001", a);
        end
        req = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hFFFB || out_id !== 2'd0 || out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL single_out: valid=%b data=%h id=%0d ovf=%b required 1 fffb 0 0",
                     out_valid, out_data, out_id, out_ovf);
        end
        drain();
    endtask

    task automatic test_backpressure_hold();
        logic [NREQ-1:0] a;
        req_data[0 +: N] = 16'h0001;
        req       = 4'b0001;
        out_ready = 1'b0;
        tick(a);
        req_data[2*N +: N] = 16'h0007;
        req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (ack !== '0 || out_valid !== 1'b1 || out_data !== 16'hFFFF || out_id !== 2'd0) begin
                fails++;
                $display("FAIL hold c=%0d: ack=%b valid=%b data=%h id=%0d required 0000 1 ffff 0",
                         c, ack, out_valid, out_data, out_id);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0100) begin
            fails++;
            $display("FAIL hold_release_ack: ack=%b required 0100", ack);
        end
        @(posedge clk);
        #1;
        req = '0;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 16'hFFF9) begin
            fails++;
            $display("FAIL hold_release_out: valid=%b id=%0d data=%h required 1 2 fff9",
                     out_valid, out_id, out_data);
        end
        drain();
    endtask

    task automatic test_arith_boundaries();
        logic [NREQ-1:0] a;
        logic [N-1:0]    ops[6];
        ops = '{16'h8000, 16'h0000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h8001};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_data[0 +: N] = ops[i];
            req = 4'b0001;
            tick(a);
            req = '0;
            checks++;
            if (out_data !== ref_neg(ops[i]) || out_ovf !== ref_ovf(ops[i])) begin
                fails++;
                $display("FAIL arith op=%h: data=%h ovf=%b required %h %b",
                         ops[i], out_data, out_ovf, ref_neg(ops[i]), ref_ovf(ops[i]));
            end
        end
`ifdef NEG_SAT_EN
        req_data[0 +: N] = 16'h8000;
        req = 4'b0001;
        tick(a);
        req = '0;
        checks++;
        if (out_data !== 16'h7FFF || out_ovf !== 1'b1) begin
            fails++;
            $display("FAIL arith_min_sat: data=%h ovf=%b required 7fff 1", out_data, out_ovf);
        end
`else
        req_data[0 +: N] = 16'h8000;
        req = 4'b0001;
        tick(a);
        req = '0;
        checks++;
        if (out_data !== 16'h8000 || out_ovf !== 1'b1) begin
            fails++;
            $display("FAIL arith_min_wrap: data=%h ovf=%b required 8000 1", out_data, out_ovf);
        end
`endif
        drain();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] a;
        logic [N-1:0]    v;
        for (int c = 0; c < 400; c++) begin
            tick(a);
            req = req & ~a;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 7))
                        0:       v = 16'h8000;
                        1:       v = 16'h0000;
                        2:       v = 16'h7FFF;
                        default: v = N'($urandom);
                    endcase
                    req_data[i*N +: N] = v;
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        drain();
    endtask

    task automatic test_reset_mid_full();
        logic [NREQ-1:0] a;
        for (int i = 0; i < NREQ; i++) req_data[i*N +: N] = N'(16'h0100 + i);
        req       = '1;
        out_ready = 1'b0;
        repeat (2) tick(a);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ack !== '0) begin
            fails++;
            $display("FAIL reset_mid: valid=%b ack=%b required 0 0000", out_valid, ack);
        end
        repeat (2) tick(a);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0001) begin
            fails++;
            $display("FAIL reset_first_ack: ack=%b required 0001", ack);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure_hold();
        test_arith_boundaries();
        test_random();
        test_reset_mid_full();
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL final_drain: %0d results still expected, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
